// File: rtl/eth_rx_dispatcher_if.sv
// Receive-side bundle between the frame decoder, the dispatcher and its
// sink controllers. The decoder/sink side drives through 'master'; the
// dispatcher connects through 'slave'.
interface eth_rx_dispatcher_if #(
  parameter int SINK_NUM = 4,
  parameter int PW       = (SINK_NUM > 1) ? $clog2(SINK_NUM) : 1
);
  logic                rx_start;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_stop;
  logic [SINK_NUM-1:0] sink_rdy;
  logic [SINK_NUM-1:0] sel;
  logic [PW-1:0]       port_number;
  logic [7:0]          dev_data;
  logic                dev_valid;
  logic                dev_done;
  logic                dev_err;
  logic                busy;
  logic [7:0]          drop_cnt;

  modport master (
    output rx_start, rx_valid, rx_data, rx_stop, sink_rdy,
    input  sel, port_number, dev_data, dev_valid, dev_done, dev_err,
           busy, drop_cnt
  );

  modport slave (
    input  rx_start, rx_valid, rx_data, rx_stop, sink_rdy,
    output sel, port_number, dev_data, dev_valid, dev_done, dev_err,
           busy, drop_cnt
  );
endinterface

// File: rtl/eth_rx_dispatcher.sv
// Routes each received frame to one sink controller. The first byte of a
// frame is a header naming the destination sink; the rest of the frame is
// forwarded to that sink if it was ready when the header arrived, otherwise
// the whole frame is discarded and counted in a saturating drop counter.
module eth_rx_dispatcher #(
  parameter int SINK_NUM = 4,
  parameter int PW       = (SINK_NUM > 1) ? $clog2(SINK_NUM) : 1
) (
  input logic                clk,
  input logic                rst_n,
  eth_rx_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PASS,
    DROP
  } state_t;

  state_t state, state_nxt;

  // Registered outputs and their next values.
  logic [SINK_NUM-1:0] sel_q, sel_nxt;
  logic [PW-1:0]       port_q, port_nxt;
  logic [7:0]          data_q, data_nxt;
  logic                valid_q, valid_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;
  logic [7:0]          drop_q;
  logic                drop_inc;

  // Header decode: destination index and its one-hot form, qualified by
  // the sink's readiness. An index with no matching sink leaves hdr_hit
  // all-zero, so out-of-range ports and busy sinks both fall into DROP.
  logic [PW-1:0]       hdr_port;
  logic [SINK_NUM-1:0] hdr_hit;
  logic                hdr_ok;

  assign hdr_port = bus.rx_data[PW-1:0];
  assign hdr_ok   = |hdr_hit;

  // One-hot match of the header index against ready sinks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hdr_hit = '0;
    for (int i = 0; i < SINK_NUM; i++) begin
      hdr_hit[i] = (hdr_port == PW'(i)) && bus.sink_rdy[i];
    end
  end

  // State and registered outputs; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      port_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state   <= state_nxt;
      sel_q   <= sel_nxt;
      port_q  <= port_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      if (drop_inc && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Next-state: rx_start always begins a new frame except when it shares
  // a cycle with rx_stop in PASS, where the old frame completes first and
  // the new frame still begins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.rx_start) state_nxt = HDR;
      HDR: begin
        if (bus.rx_start)      state_nxt = HDR;
        else if (bus.rx_stop)  state_nxt = IDLE;
        else if (bus.rx_valid) state_nxt = hdr_ok ? PASS : DROP;
      end
      PASS: begin
        if (bus.rx_stop)       state_nxt = bus.rx_start ? HDR : IDLE;
        else if (bus.rx_start) state_nxt = HDR;
      end
      DROP: begin
        if (bus.rx_start)      state_nxt = HDR;
        else if (bus.rx_stop)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output next values: route on the header, forward in PASS, pulse
  // done/err on frame end, count frames that never reach a sink.
  always_comb begin
    sel_nxt   = sel_q;
    port_nxt  = port_q;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      HDR: begin
        if (bus.rx_start || bus.rx_stop) begin
          drop_inc = 1'b1;
        end else if (bus.rx_valid && hdr_ok) begin
          sel_nxt  = hdr_hit;
          port_nxt = hdr_port;
        end
      end
      PASS: begin
        if (bus.rx_stop) begin
          done_nxt = 1'b1;
          sel_nxt  = '0;
          port_nxt = '0;
          if (bus.rx_valid) begin
            data_nxt  = bus.rx_data;
            valid_nxt = 1'b1;
          end
        end else if (bus.rx_start) begin
          // Aborted frame: any coincident byte belongs to the new frame.
          err_nxt  = 1'b1;
          sel_nxt  = '0;
          port_nxt = '0;
        end else if (bus.rx_valid) begin
          data_nxt  = bus.rx_data;
          valid_nxt = 1'b1;
        end
      end
      DROP: begin
        if (bus.rx_start || bus.rx_stop) drop_inc = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.port_number = port_q;
  assign bus.dev_data    = data_q;
  assign bus.dev_valid   = valid_q;
  assign bus.dev_done    = done_q;
  assign bus.dev_err     = err_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Self-checking bench for eth_rx_dispatcher: a directed vector table,
// hand-written reset and saturation sequences, and random traffic checked
// against a frame-level reference model.
module tb_eth_rx_dispatcher;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  eth_rx_dispatcher_if #(.SINK_NUM(N)) bus ();

  eth_rx_dispatcher #(.SINK_NUM(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       v;
    logic [7:0] d;
    logic       sp;
    logic [3:0] rdy;
    logic [3:0] e_sel;
    logic [1:0] e_port;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_done;
    logic       e_err;
    logic       e_busy;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic st, input logic v, input logic [7:0] d,
                              input logic sp, input logic [3:0] rdy,
                              input logic [3:0] e_sel, input logic [1:0] e_port,
                              input logic e_v, input logic [7:0] e_d,
                              input logic e_done, input logic e_err,
                              input logic e_busy, input logic [7:0] e_drop);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.sp = sp; r.rdy = rdy;
    r.e_sel = e_sel; r.e_port = e_port; r.e_v = e_v; r.e_d = e_d;
    r.e_done = e_done; r.e_err = e_err; r.e_busy = e_busy; r.e_drop = e_drop;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input logic [7:0] d,
                       input logic sp, input logic [3:0] rdy);
    bus.rx_start = st;
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rx_stop  = sp;
    bus.sink_rdy = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 4'hF);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, " sel"},       32'(bus.sel), 0);
    check({tag, " port"},      32'(bus.port_number), 0);
    check({tag, " dev_data"},  32'(bus.dev_data), 0);
    check({tag, " dev_valid"}, 32'(bus.dev_valid), 0);
    check({tag, " dev_done"},  32'(bus.dev_done), 0);
    check({tag, " dev_err"},   32'(bus.dev_err), 0);
    check({tag, " busy"},      32'(bus.busy), 0);
    check({tag, " drop_cnt"},  32'(bus.drop_cnt), 0);
  endtask

  // Frame-level reference: m_cur is the destination of the current frame
  // (NO_FRAME between frames, WAIT_HDR before the header, DROPPING when
  // the frame is being discarded, else the sink index).
  localparam int NO_FRAME = -2;
  localparam int WAIT_HDR = -1;
  localparam int DROPPING = N;

  int         m_cur;
  int         m_drop;
  logic [3:0] m_sel;
  int         m_port;
  logic [7:0] m_data;
  logic       m_v, m_done, m_err;

  task automatic model_reset();
    m_cur = NO_FRAME; m_drop = 0; m_sel = 0; m_port = 0; m_data = 0;
    m_v = 0; m_done = 0; m_err = 0;
  endtask

  task automatic frame_lost();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_step(input logic st, input logic v, input logic [7:0] d,
                            input logic sp, input logic [3:0] rdy);
    int p;
    m_v = 0; m_done = 0; m_err = 0;
    if (m_cur == NO_FRAME) begin
      if (st) m_cur = WAIT_HDR;
    end else if (m_cur == WAIT_HDR) begin
      if (st || sp) begin
        frame_lost();
        m_cur = st ? WAIT_HDR : NO_FRAME;
      end else if (v) begin
        p = int'(d) % N;
        if (rdy[p]) begin
          m_cur = p; m_sel = 4'(1 << p); m_port = p;
        end else begin
          m_cur = DROPPING;
        end
      end
    end else if (m_cur == DROPPING) begin
      if (st || sp) begin
        frame_lost();
        m_cur = st ? WAIT_HDR : NO_FRAME;
      end
    end else begin
      if (v && (sp || !st)) begin
        m_data = d; m_v = 1;
      end
      if (sp || st) begin
        m_done = sp; m_err = !sp;
        m_sel = 0; m_port = 0;
        m_cur = st ? WAIT_HDR : NO_FRAME;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 4'hF);

    // Reset state.
    tick();
    check_all_reset("reset");
    rst_n = 1'b1;

    // Directed vectors (inputs ... expected outputs after the edge).
    //   st v  data  sp rdy   sel port ev  edata done err busy drop
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);  // basic route
    add(0, 1, 8'h02, 0, 4'hF, 4'h4, 2, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'hA1, 0, 4'hF, 4'h4, 2, 1, 8'hA1, 0, 0, 1, 0);
    add(0, 1, 8'hB2, 0, 4'hF, 4'h4, 2, 1, 8'hB2, 0, 0, 1, 0);
    add(0, 1, 8'hC3, 0, 4'hF, 4'h4, 2, 1, 8'hC3, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);  // sink 1 not ready
    add(0, 1, 8'h01, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'h11, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'h22, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'h33, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 1);  // abort in PASS
    add(0, 1, 8'h02, 0, 4'hF, 4'h4, 2, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'hA1, 0, 4'hF, 4'h4, 2, 1, 8'hA1, 0, 0, 1, 1);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 1, 1, 1);
    add(0, 1, 8'h00, 0, 4'hF, 4'h1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(0, 1, 8'h5A, 0, 4'hF, 4'h1, 0, 1, 8'h5A, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 1);  // empty frame
    add(0, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 0, 2);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 2);  // last byte with stop
    add(0, 1, 8'h03, 0, 4'hF, 4'h8, 3, 0, 8'h00, 0, 0, 1, 2);
    add(0, 1, 8'h77, 1, 4'hF, 4'h0, 0, 1, 8'h77, 1, 0, 0, 2);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 2);  // start+stop in PASS
    add(0, 1, 8'h01, 0, 4'hF, 4'h2, 1, 0, 8'h00, 0, 0, 1, 2);
    add(1, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 1, 0, 1, 2);
    add(0, 1, 8'h00, 0, 4'hF, 4'h1, 0, 0, 8'h00, 0, 0, 1, 2);
    add(0, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 1, 0, 0, 2);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 2);  // rdy drops in PASS
    add(0, 1, 8'h02, 0, 4'hF, 4'h4, 2, 0, 8'h00, 0, 0, 1, 2);
    add(0, 1, 8'h44, 0, 4'h0, 4'h4, 2, 1, 8'h44, 0, 0, 1, 2);
    add(0, 0, 8'h00, 1, 4'h0, 4'h0, 0, 0, 8'h00, 1, 0, 0, 2);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 2);  // header with stop
    add(0, 1, 8'h01, 1, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 0, 3);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 3);  // aborts in DROP/HDR
    add(0, 1, 8'h01, 0, 4'hD, 4'h0, 0, 0, 8'h00, 0, 0, 1, 3);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 4);
    add(1, 0, 8'h00, 0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 1, 5);
    add(0, 0, 8'h00, 1, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 0, 6);
    add(0, 1, 8'h02, 1, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 0, 6);  // IDLE ignores bytes

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].sp, tbl[i].rdy);
      tick();
      check($sformatf("row%0d sel", i),       32'(bus.sel), 32'(tbl[i].e_sel));
      check($sformatf("row%0d port", i),      32'(bus.port_number), 32'(tbl[i].e_port));
      check($sformatf("row%0d dev_valid", i), 32'(bus.dev_valid), 32'(tbl[i].e_v));
      if (tbl[i].e_v)
        check($sformatf("row%0d dev_data", i), 32'(bus.dev_data), 32'(tbl[i].e_d));
      check($sformatf("row%0d dev_done", i),  32'(bus.dev_done), 32'(tbl[i].e_done));
      check($sformatf("row%0d dev_err", i),   32'(bus.dev_err), 32'(tbl[i].e_err));
      check($sformatf("row%0d busy", i),      32'(bus.busy), 32'(tbl[i].e_busy));
      check($sformatf("row%0d drop_cnt", i),  32'(bus.drop_cnt), 32'(tbl[i].e_drop));
    end

    // Saturation: 300 empty frames, counter must stop at 255.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      drive(1, 0, 8'h00, 0, 4'hF);
      tick();
      drive(0, 0, 8'h00, 1, 4'hF);
      tick();
      if (k == 254) check("sat drop_cnt@254", 32'(bus.drop_cnt), 254);
      if (k == 255) check("sat drop_cnt@255", 32'(bus.drop_cnt), 255);
    end
    check("sat drop_cnt@300", 32'(bus.drop_cnt), 255);

    // Reset in the middle of a forwarded frame.
    do_reset();
    drive(1, 0, 8'h00, 0, 4'hF); tick();
    drive(0, 1, 8'h02, 0, 4'hF); tick();
    drive(0, 1, 8'hA1, 0, 4'hF); tick();
    drive(0, 1, 8'hB2, 0, 4'hF); tick();
    check("midrst pre sel", 32'(bus.sel), 32'h4);
    check("midrst pre data", 32'(bus.dev_data), 32'hB2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_reset("midrst async");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 8'(8'h30 + k), (k == 4), 4'hF);
      tick();
      check($sformatf("postrst%0d dev_valid", k), 32'(bus.dev_valid), 0);
      check($sformatf("postrst%0d busy", k),      32'(bus.busy), 0);
      check($sformatf("postrst%0d sel", k),       32'(bus.sel), 0);
      check($sformatf("postrst%0d done", k),      32'(bus.dev_done), 0);
    end

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       st, v, sp;
      logic [7:0] d;
      logic [3:0] rdy;
      st  = ($urandom_range(0, 19) == 0);
      sp  = ($urandom_range(0, 14) == 0);
      v   = !st && ($urandom_range(0, 9) < 6);
      d   = 8'($urandom);
      rdy = 4'($urandom);
      drive(st, v, d, sp, rdy);
      model_step(st, v, d, sp, rdy);
      tick();
      check($sformatf("rnd%0d sel", c),       32'(bus.sel), 32'(m_sel));
      check($sformatf("rnd%0d port", c),      32'(bus.port_number), 32'(m_port));
      check($sformatf("rnd%0d dev_valid", c), 32'(bus.dev_valid), 32'(m_v));
      check($sformatf("rnd%0d dev_data", c),  32'(bus.dev_data), 32'(m_data));
      check($sformatf("rnd%0d dev_done", c),  32'(bus.dev_done), 32'(m_done));
      check($sformatf("rnd%0d dev_err", c),   32'(bus.dev_err), 32'(m_err));
      check($sformatf("rnd%0d busy", c),      32'(bus.busy), 32'(m_cur != NO_FRAME));
      check($sformatf("rnd%0d drop_cnt", c),  32'(bus.drop_cnt), 32'(m_drop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_dispatcher.md
ETH_RX_DISPATCHER -- requirements
Module: eth_rx_dispatcher

Interface
REQ-001 Parameter SINK_NUM, default 4, number of sink controllers (2..16).
REQ-002 Parameter PW, default log2(SINK_NUM) rounded up (min 1), port-number width.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_start  input  1  decoder pulse: new frame begins.
REQ-006 rx_valid  input  1  rx_data holds a valid byte this cycle.
REQ-007 rx_data  input  8  received byte.
REQ-008 rx_stop  input  1  decoder pulse: frame ended (after or with last valid byte).
REQ-009 sink_rdy  input  SINK_NUM  per-sink "can accept a frame" flag.
REQ-010 sel  output  SINK_NUM  one-hot selected sink, registered.
REQ-011 port_number  output  PW  index of selected sink, registered.
REQ-012 dev_data  output  8  forwarded byte, registered.
REQ-013 dev_valid  output  1  dev_data valid for selected sink.
REQ-014 dev_done  output  1  one-cycle pulse: frame delivered completely.
REQ-015 dev_err  output  1  one-cycle pulse: frame aborted mid-delivery.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 drop_cnt  output  8  count of dropped frames, saturating at 255.

Function
REQ-018 FSM states IDLE, HDR, PASS, DROP; encoding free.
REQ-019 IDLE: rx_start -> HDR; rx_valid/rx_stop ignored.
REQ-020 HDR: first rx_valid byte is header; port = rx_data[PW-1:0]; header byte consumed, never forwarded.
REQ-021 HDR: port < SINK_NUM and sink_rdy[port]=1 on header cycle -> PASS; next cycle sel[port]=1, port_number=port.
REQ-022 HDR: port >= SINK_NUM or sink_rdy[port]=0 -> DROP.
REQ-023 HDR: rx_stop with no header byte (or coincident with header byte) -> IDLE, frame counted as dropped.
REQ-024 PASS: each rx_valid byte -> dev_data=rx_data, dev_valid=1 exactly one cycle later; no bytes lost, reordered or duplicated.
REQ-025 PASS: rx_stop -> dev_done=1 next cycle; sel and port_number cleared same cycle as dev_done; state IDLE.
REQ-026 PASS: rx_valid with rx_stop same cycle -> byte forwarded and dev_done asserted together, next cycle.
REQ-027 sink_rdy sampled only in HDR; deassertion during PASS has no effect.
REQ-028 DROP: all bytes discarded (dev_valid=0, sel=0); rx_stop -> IDLE, drop_cnt+1.
REQ-029 drop_cnt saturates at 255, never wraps.
REQ-030 rx_start in HDR/PASS/DROP = abort: PASS -> dev_err pulse next cycle, sel cleared; DROP/HDR -> drop_cnt+1; in all cases state HDR for the new frame.
REQ-031 rx_start and rx_stop same cycle in PASS: dev_done (not dev_err) for old frame, then HDR.
REQ-032 dev_done and dev_err never asserted together; at most one per frame.
REQ-033 sel at most one bit high; sel nonzero only in PASS and during dev_done/dev_err cycle's preceding state.
REQ-034 busy combinational from state; all other outputs registered.

Reset
REQ-035 rst_n low: state IDLE, sel=0, port_number=0, dev_data=0, dev_valid=0, dev_done=0, dev_err=0, busy=0, drop_cnt=0.
REQ-036 Reset mid-frame discards the frame without dev_done/dev_err; after release, bytes before next rx_start ignored.

Verification
REQ-037 SINK_NUM=4, sink_rdy=4'b1111, rx_start, bytes 02,A1,B2,C3, rx_stop -> sel=0100, port_number=2, dev_data A1,B2,C3 each one cycle after input, dev_done one cycle after rx_stop.
REQ-038 sink_rdy=4'b1101, header 01, 3 bytes, rx_stop -> sel stays 0, dev_valid never high, drop_cnt 0->1.
REQ-039 Header 02, A1 forwarded, rx_start before rx_stop -> dev_err pulse, sel cleared, new header 00 routes to sink 0.
REQ-040 rx_start then rx_stop with no bytes -> no sel, drop_cnt+1, FSM back in IDLE.
REQ-041 300 consecutive dropped frames -> drop_cnt stops at 255.
REQ-042 Assert rst_n low in PASS after 2 bytes -> all outputs reset values immediately; bytes after release without rx_start produce no dev_valid.
